mem_fetch_seq: RTL and testbench

MEM_FETCH_SEQ -- requirements
Module: mem_fetch_seq

---
 rtl/mem_fetch_seq.sv | 184 ++++++++++++++++++
 tb/tb_mem_fetch_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fetch_seq.sv
// mem_fetch_seq: sequential word fetcher with a 2-entry output FIFO.
//
// Purpose: on start, reads 32-bit words from BASE_ADDR upward, one word per
// cycle. Each word that is not END_WORD is pushed into a 2-deep FIFO together
// with its byte address. The run stops at the sentinel. The FSM drains the
// FIFO and then parks in DONE.
//
// Optional feature: define FETCH_LIMIT_EN to also stop a run after MAX_WORDS
// words. Such a run ends in DONE with overrun set. Without the macro, overrun
// is tied low and MAX_WORDS has no effect.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle run request (only honoured in IDLE/DONE)
//   M_EnWR, M_Size      memory control, held at read / word size
//   M_ABus, M_DBusW     memory byte address, write data (held at zero)
//   M_DBusR             memory read data, combinational from M_ABus
//   out_valid/ready     FIFO head handshake
//   out_data, out_addr  FIFO head word and its byte address
//   busy, done          FSM in FETCH/DRAIN, FSM in DONE
//   overrun             run ended on the word limit
//   count               non-sentinel words pushed in the current run

`ifndef MM_ENB_R
`define MM_ENB_R 1'b1
`endif
`ifndef MW_Word
`define MW_Word 2'b10
`endif

module mem_fetch_seq #(
  parameter logic [31:0] BASE_ADDR = 32'd2048,
  parameter logic [31:0] END_WORD  = 32'h0000FFFF,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        M_EnWR,
  output logic [1:0]  M_Size,
  output logic [31:0] M_ABus,
  output logic [31:0] M_DBusW,
  input  logic [31:0] M_DBusR,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        overrun,
  output logic [31:0] count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] head_data_q, head_data_d, head_addr_q, head_addr_d;
  logic [31:0] tail_data_q, tail_data_d, tail_addr_q, tail_addr_d;

  logic [1:0]  occ_after;
  logic        pop, push, flush, limit_hit;

`ifdef FETCH_LIMIT_EN
  assign limit_hit = (count_q >= 32'(MAX_WORDS));
`else
  logic unused_max_words;
  assign unused_max_words = |32'(MAX_WORDS);
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    overrun_d   = overrun_q;
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    push        = 1'b0;
    flush       = 1'b0;

    pop       = (occ_q != 2'd0) && out_ready;
    // A slot freed by this edge's pop can be refilled on the same edge.
    occ_after = occ_q - {1'b0, pop};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_FETCH;
          addr_d    = BASE_ADDR;
          count_d   = 32'd0;
          overrun_d = 1'b0;
          flush     = 1'b1;
        end
      end
      S_FETCH: begin
        if (limit_hit) begin
          overrun_d = 1'b1;
          state_d   = S_DRAIN;
        end else if (occ_after < 2'd2) begin
          if (M_DBusR != END_WORD) begin
            push    = 1'b1;
            addr_d  = addr_q + 32'd4;
            count_d = count_q + 32'd1;
          end else begin
            // Nothing left to drain: go straight to DONE.
            state_d = (occ_after == 2'd0) ? S_DONE : S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (occ_after == 2'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO is a head/tail pair: the head drives the outputs directly.
    if (pop && (occ_q == 2'd2)) begin
      head_data_d = tail_data_q;
      head_addr_d = tail_addr_q;
    end
    if (push) begin
      if (occ_after == 2'd0) begin
        head_data_d = M_DBusR;
        head_addr_d = addr_q;
      end else begin
        tail_data_d = M_DBusR;
        tail_addr_d = addr_q;
      end
    end
    occ_d = flush ? 2'd0 : (occ_after + {1'b0, push});

    busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE_ADDR;
      count_q     <= 32'd0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      occ_q       <= 2'd0;
      head_data_q <= 32'd0;
      head_addr_q <= 32'd0;
      tail_data_q <= 32'd0;
      tail_addr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
    end
  end

  assign M_EnWR    = `MM_ENB_R;
  assign M_Size    = `MW_Word;
  assign M_DBusW   = 32'h0;
  assign M_ABus    = addr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_addr  = head_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign count     = count_q;

endmodule

// File: tb/tb_mem_fetch_seq.sv
// tb_mem_fetch_seq: randomized scoreboard bench for mem_fetch_seq.
// The memory image is a small array. The expected word stream for each run is
// derived from that image: walk upward from the base address until the
// sentinel (or the word limit when FETCH_LIMIT_EN is defined). A negedge
// monitor pops and compares every accepted word.

`ifndef MM_ENB_R
`define MM_ENB_R 1'b1
`endif
`ifndef MW_Word
`define MW_Word 2'b10
`endif

module tb_mem_fetch_seq;
  localparam logic [31:0] BASE = 32'd2048;
  localparam logic [31:0] ENDW = 32'h0000FFFF;
  localparam int          LIM  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        M_EnWR;
  logic [1:0]  M_Size;
  logic [31:0] M_ABus, M_DBusW, M_DBusR;
  logic        out_valid;
  logic [31:0] out_data, out_addr;
  logic        busy, done, overrun;
  logic [31:0] count;

  mem_fetch_seq #(.BASE_ADDR(BASE), .END_WORD(ENDW), .MAX_WORDS(LIM)) dut (
    .clk(clk), .rst(rst), .start(start),
    .M_EnWR(M_EnWR), .M_Size(M_Size), .M_ABus(M_ABus), .M_DBusW(M_DBusW),
    .M_DBusR(M_DBusR),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .busy(busy), .done(done), .overrun(overrun), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 64 words from BASE; outside that, a filler that is never the sentinel.
  logic [31:0] mem [0:63];
  logic [31:0] rd_off;
  always_comb begin
    rd_off = M_ABus - BASE;
    if (rd_off < 32'd256 && rd_off[1:0] == 2'b00) M_DBusR = mem[rd_off[7:2]];
    else M_DBusR = M_ABus ^ 32'h5A5A_0000;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  int          acc = 0;
  int          first_acc = -1;
  int          last_acc = -1;
  int          ready_mode = 0;
  bit          hold_prev = 0;
  logic [31:0] prev_data, prev_addr;
  bit          occ_ok;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (busy) begin
        check("count_vs_addr", count, (M_ABus - BASE) >> 2);
        occ_ok = ((int'(count) - acc) <= 2);
        check("fifo_depth_bound", 32'(occ_ok), 32'd1);
      end
      if (hold_prev) begin
        check("valid_held", 32'(out_valid), 32'd1);
        check("data_stable", out_data, prev_data);
        check("addr_stable", out_addr, prev_addr);
      end
      if (out_valid) begin
        check("no_sentinel_out", 32'(out_data == ENDW), 32'd0);
        if (out_ready) begin
          if (exp_data.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_word: got data 0x%0h addr 0x%0h, expected no word", out_data, out_addr);
          end else begin
            check("out_data", out_data, exp_data.pop_front());
            check("out_addr", out_addr, exp_addr.pop_front());
            acc++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_addr = out_addr;
    end
  end

  // Consumer: 0 = always ready, 1 = toggle, 2 = random
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic load_image(input int n, input bit with_end);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == ENDW) w = w ^ 32'd1;
      mem[i] = w;
    end
    if (with_end) mem[n] = ENDW;
  endtask

  // Reference: the words in front of the sentinel, truncated at the limit when enabled.
  task automatic build_expected(input int n, output int exp_n, output bit exp_ov);
    exp_data.delete();
    exp_addr.delete();
    exp_n  = n;
    exp_ov = 1'b0;
`ifdef FETCH_LIMIT_EN
    if (n >= LIM) begin
      exp_n  = LIM;
      exp_ov = 1'b1;
    end
`endif
    for (int i = 0; i < exp_n; i++) begin
      exp_data.push_back(mem[i]);
      exp_addr.push_back(BASE + 32'(4 * i));
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input int n, input int rmode, input bit mid_start);
    int exp_n;
    bit exp_ov;
    int s_cyc;
    build_expected(n, exp_n, exp_ov);
    acc = 0; first_acc = -1; last_acc = -1;
    ready_mode = rmode;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_cyc = cyc;
    if (mid_start) begin
      @(posedge clk);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(tag);
    check({tag, "_count"}, count, 32'(exp_n));
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_ov));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_accepted"}, 32'(acc), 32'(exp_n));
    check({tag, "_left_in_sb"}, 32'(exp_data.size()), 32'd0);
    if (rmode == 0 && exp_n > 0) begin
      check({tag, "_first_latency"}, 32'(first_acc - s_cyc), 32'd1);
      check({tag, "_back_to_back"}, 32'(last_acc - first_acc), 32'(exp_n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, n_r, m_r, dmy_n;
    bit dmy_ov;
    load_image(0, 1);
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_addr", out_addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_abus", M_ABus, BASE);
    check("enwr", 32'(M_EnWR), 32'(`MM_ENB_R));
    check("msize", 32'(M_Size), 32'(`MW_Word));
    check("dbusw", M_DBusW, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic run, consumer always ready
    load_image(4, 1);
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    run("basic", 4, 0, 0);

    // Same image, consumer toggling
    run("toggle", 4, 1, 0);

    // Start pulsed mid-run is ignored
    run("midstart", 4, 0, 1);

    // Sentinel at the first address
    load_image(0, 1);
    build_expected(0, dmy_n, dmy_ov);
    acc = 0;
    ready_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("sent_done_early", 32'(done), 32'd0);
    check("sent_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("sent_done", 32'(done), 32'd1);
    check("sent_count", count, 32'd0);
    check("sent_busy_after", 32'(busy), 32'd0);
    check("sent_valid", 32'(out_valid), 32'd0);

    // Reset mid-run after two accepted words
    load_image(8, 1);
    build_expected(8, dmy_n, dmy_ov);
    acc = 0; first_acc = -1;
    ready_mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (acc < 2 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("midrst_two_accepted", 32'(acc), 32'd2);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_addr", out_addr, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_count", count, 32'd0);
    check("midrst_abus", M_ABus, BASE);
    exp_data.delete();
    exp_addr.delete();
    acc = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("postrst_idle_busy", 32'(busy), 32'd0);
    check("postrst_idle_done", 32'(done), 32'd0);
    check("postrst_no_valid", 32'(out_valid), 32'd0);
    run("after_rst", 8, 0, 0);

`ifdef FETCH_LIMIT_EN
    // No sentinel in reach: the limit ends the run
    load_image(5, 0);
    run("limit", 5, 0, 0);
`endif

    // Randomized images and consumer behaviour
    for (int r = 0; r < 8; r++) begin
      n_r = $urandom_range(0, 10);
      m_r = $urandom_range(0, 2);
      load_image(n_r, 1);
      run("rand", n_r, m_r, 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
